// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle RV32I datapath: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and enables.
module multicycle_controller #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic       bus_error
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
  } state_t;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          bus_error_reg;
  logic          mem_state, waiting, timeout;
  logic          alu_f3_ok, br_f3_ok;
  logic [2:0]    alu_func;
  logic          mem_write_en, ir_write_en, pc_write_en, reg_write_en;

  assign mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                     (state_reg == S_MEMWRITE);
  assign waiting   = mem_state && !mem_ready;
  // Timeout fires on the WAIT_LIMIT-th consecutive stalled cycle.
  assign timeout   = (WAIT_LIMIT != 0) && waiting && (wait_cnt_reg == LIMIT_M1);

  always_comb begin
    wait_cnt_next = '0;
    if (waiting && !timeout && (WAIT_LIMIT != 0))
      wait_cnt_next = wait_cnt_reg + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      wait_cnt_reg  <= '0;
      bus_error_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (timeout)
        bus_error_reg <= 1'b1;
    end
  end

  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = alu_f3_ok ? S_EXECR  : S_ILLEGAL;
          7'b0010011:             state_next = alu_f3_ok ? S_EXECI  : S_ILLEGAL;
          7'b1100011:             state_next = br_f3_ok  ? S_BRANCH : S_ILLEGAL;
          7'b1101111:             state_next = S_JAL;
          default:                state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_ILLEGAL;
    endcase
    if (timeout)
      state_next = S_ILLEGAL;
  end

  // Only R-type with funct7b5 turns funct3=000 into a subtract.
  always_comb begin
    case (funct3)
      3'b000:  alu_func = ((state_reg == S_EXECR) && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_func = 3'b101;
      3'b110:  alu_func = 3'b011;
      3'b111:  alu_func = 3'b010;
      default: alu_func = 3'b000;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_write_en = 1'b0;
    adr_src      = 1'b0;
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    reg_write_en = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    imm_src      = 2'b00;
    result_src   = 2'b00;
    alu_control  = 3'b000;
    illegal      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write_en = mem_ready;
        pc_write_en = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write_en = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req      = 1'b1;
        mem_write_en = 1'b1;
        adr_src      = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_func;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_func;
      end
      S_ALUWB:    reg_write_en = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write_en = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? ~zero : 1'b0;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_write_en = 1'b1;
      end
      S_ILLEGAL:  illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

  // Write strobes drop combinationally while reset is held, even mid-access.
  assign mem_write = mem_write_en & ~reset;
  assign ir_write  = ir_write_en  & ~reset;
  assign pc_write  = pc_write_en  & ~reset;
  assign reg_write = reg_write_en & ~reset;
  assign bus_error = bus_error_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction sequences push
// hand-computed output vectors; a negedge monitor pops and compares them.
module tb_multicycle_controller;

  localparam int WL = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0] alu_control;
  logic       illegal, bus_error;

  multicycle_controller #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .result_src(result_src), .alu_control(alu_control),
    .illegal(illegal), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  // Layout: req wr adr ir pc rw | a b imm res | alu | ill be
  localparam logic [18:0] FETCH_R  = 19'b1_0_0_1_1_0_00_10_00_10_000_0_0;
  localparam logic [18:0] FETCH_W  = 19'b1_0_0_0_0_0_00_10_00_10_000_0_0;
  localparam logic [18:0] DECODE   = 19'b0_0_0_0_0_0_01_01_10_00_000_0_0;
  localparam logic [18:0] MEMADR_L = 19'b0_0_0_0_0_0_10_01_00_00_000_0_0;
  localparam logic [18:0] MEMADR_S = 19'b0_0_0_0_0_0_10_01_01_00_000_0_0;
  localparam logic [18:0] MEMREAD  = 19'b1_0_1_0_0_0_00_00_00_00_000_0_0;
  localparam logic [18:0] MEMWB    = 19'b0_0_0_0_0_1_00_00_00_01_000_0_0;
  localparam logic [18:0] MEMWRITE = 19'b1_1_1_0_0_0_00_00_00_00_000_0_0;
  localparam logic [18:0] ALUWB    = 19'b0_0_0_0_0_1_00_00_00_00_000_0_0;
  localparam logic [18:0] JAL      = 19'b0_0_0_0_1_0_01_10_00_00_000_0_0;
  localparam logic [18:0] BR_T     = 19'b0_0_0_0_1_0_10_00_00_00_001_0_0;
  localparam logic [18:0] BR_N     = 19'b0_0_0_0_0_0_10_00_00_00_001_0_0;
  localparam logic [18:0] ILL      = 19'b0_0_0_0_0_0_00_00_00_00_000_1_0;
  localparam logic [18:0] BUSERR   = 19'b0_0_0_0_0_0_00_00_00_00_000_1_1;
  localparam logic [13:0] EXECR_HI = 14'b0_0_0_0_0_0_10_00_00_00;
  localparam logic [13:0] EXECI_HI = 14'b0_0_0_0_0_0_10_01_00_00;

  typedef struct {
    logic [18:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [18:0] act;
  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, imm_src, result_src, alu_control,
                illegal, bus_error};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %b required %b", e.name, act, e.v);
      end else begin
        $display("ok   %s: %b", e.name, act);
      end
    end
  end

  task automatic cyc(input logic mr, input logic z, input logic [18:0] e, input string nm);
    mem_ready = mr;
    zero      = z;
    q.push_back('{v: e, name: nm});
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  // mem_ready held high during reset: ir/pc write must stay low regardless.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    q.push_back('{v: FETCH_W, name: "reset_held"});
    @(posedge clk);
    #1;
    q.push_back('{v: FETCH_W, name: "reset_held"});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fetch_decode();
    cyc(1'b1, 1'b0, FETCH_R, "fetch");
    cyc(1'b1, 1'b0, DECODE, "decode");
  endtask

  task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [2:0] alu, input string nm);
    set_instr(o, f3, f7);
    fetch_decode();
    cyc(1'b0, 1'b0, {(o == 7'b0110011) ? EXECR_HI : EXECI_HI, alu, 2'b00}, nm);
    cyc(1'b0, 1'b0, ALUWB, "aluwb");
  endtask

  task automatic branch_instr(input logic [2:0] f3, input logic z, input logic [18:0] e,
                              input string nm);
    set_instr(7'b1100011, f3, 1'b0);
    fetch_decode();
    cyc(1'b1, z, e, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // lw with memory always ready
    fetch_decode();
    cyc(1'b1, 1'b0, MEMADR_L, "lw_memadr");
    cyc(1'b1, 1'b0, MEMREAD, "lw_memread");
    cyc(1'b1, 1'b0, MEMWB, "lw_memwb");

    // sw with three stall cycles
    set_instr(7'b0100011, 3'b010, 1'b0);
    fetch_decode();
    cyc(1'b1, 1'b0, MEMADR_S, "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, MEMWRITE, "sw_stall");
    cyc(1'b1, 1'b0, MEMWRITE, "sw_done");
    cyc(1'b0, 1'b0, FETCH_W, "sw_back_fetch");
    cyc(1'b1, 1'b0, FETCH_R, "fetch_after_stall");
    cyc(1'b0, 1'b0, DECODE, "decode");
    cyc(1'b0, 1'b0, MEMADR_S, "sw_memadr");
    cyc(1'b1, 1'b0, MEMWRITE, "sw_done");

    // branches
    branch_instr(3'b000, 1'b1, BR_T, "beq_taken");
    branch_instr(3'b000, 1'b0, BR_N, "beq_not_taken");
    branch_instr(3'b001, 1'b1, BR_N, "bne_not_taken");
    branch_instr(3'b001, 1'b0, BR_T, "bne_taken");

    // ALU ops
    alu_instr(7'b0110011, 3'b000, 1'b1, 3'b001, "r_sub");
    alu_instr(7'b0110011, 3'b000, 1'b0, 3'b000, "r_add");
    alu_instr(7'b0010011, 3'b000, 1'b1, 3'b000, "i_addi_f7");
    alu_instr(7'b0110011, 3'b111, 1'b0, 3'b010, "r_and");
    alu_instr(7'b0010011, 3'b110, 1'b0, 3'b011, "i_ori");
    alu_instr(7'b0110011, 3'b010, 1'b0, 3'b101, "r_slt");

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    fetch_decode();
    cyc(1'b0, 1'b0, JAL, "jal");
    cyc(1'b0, 1'b0, ALUWB, "jal_aluwb");

    // wait counter must clear when mem_ready arrives
    set_instr(7'b0110011, 3'b000, 1'b0);
    for (int i = 0; i < 200; i++) cyc(1'b0, 1'b0, FETCH_W, "fetch_wait_a");
    cyc(1'b1, 1'b0, FETCH_R, "fetch_wait_a_done");
    cyc(1'b0, 1'b0, DECODE, "decode");
    cyc(1'b0, 1'b0, {EXECR_HI, 3'b000, 2'b00}, "r_add");
    cyc(1'b0, 1'b0, ALUWB, "aluwb");
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, FETCH_W, "fetch_wait_b");
    cyc(1'b1, 1'b0, FETCH_R, "fetch_wait_b_done");
    cyc(1'b0, 1'b0, DECODE, "decode");
    cyc(1'b0, 1'b0, {EXECR_HI, 3'b000, 2'b00}, "r_add");
    cyc(1'b0, 1'b0, ALUWB, "aluwb");

    // unsupported opcode: sticky for 20 cycles, then reset
    set_instr(7'b0110111, 3'b000, 1'b0);
    fetch_decode();
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ILL, "illegal_hold");
    do_reset();
    cyc(1'b0, 1'b0, FETCH_W, "after_illegal_reset");

    // unsupported funct3 on R-type and branch
    set_instr(7'b0110011, 3'b001, 1'b0);
    cyc(1'b1, 1'b0, FETCH_R, "fetch");
    cyc(1'b1, 1'b0, DECODE, "decode");
    cyc(1'b1, 1'b0, ILL, "r_bad_funct3");
    do_reset();
    set_instr(7'b1100011, 3'b100, 1'b0);
    fetch_decode();
    cyc(1'b1, 1'b0, ILL, "br_bad_funct3");
    do_reset();

    // fetch timeout
    for (int i = 0; i < WL; i++) cyc(1'b0, 1'b0, FETCH_W, "fetch_timeout_wait");
    cyc(1'b0, 1'b0, BUSERR, "bus_error");
    cyc(1'b1, 1'b0, BUSERR, "bus_error_hold");
    do_reset();
    cyc(1'b1, 1'b0, FETCH_R, "after_buserr_reset");

    // reset in the middle of a stalled store
    set_instr(7'b0100011, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, DECODE, "decode");
    cyc(1'b0, 1'b0, MEMADR_S, "sw_memadr");
    cyc(1'b0, 1'b0, MEMWRITE, "sw_stall");
    cyc(1'b0, 1'b0, MEMWRITE, "sw_stall");
    do_reset();
    cyc(1'b1, 1'b0, FETCH_R, "after_midwrite_reset");

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
